mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single CPU-side memory bus (addr_bus/data_bus/mem_read/mem_write/mem_ready) between two requesters.
- Requester 0 is the cpu_core fetch/load-store port. Requester 1 is a DMA/program-loader port.
- Arbitration is round-robin, with one outstanding transaction at a time.
- A watchdog terminates any access whose mem_ready never arrives, so a hung slave cannot stall the pipeline forever.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 256, ACCESS cycles allowed without mem_ready before an error completion (legal range 2..65535).
- ERR_DATA, 32'hDEADBEEF, value returned on rdata for a timed-out read.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 transaction request; held until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  DATA_W  write data.
- m0_rdata  out  DATA_W  read data, valid while m0_ack = 1.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  qualifies m0_ack; 1 = timeout.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: identical set for requester 1.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_rdata  in  DATA_W  downstream read data, sampled when mem_ready = 1.
- mem_read  out  1  downstream read strobe.
- mem_write  out  1  downstream write strobe.
- mem_ready  in  1  downstream completion.
- grant  out  1  index of the owner of the current or most recent access.
- busy  out  1  1 while in ACCESS.

Behaviour:
- States: IDLE and ACCESS.
- Reset values:
  - State = IDLE.
  - All ack, err, mem_read, mem_write and busy outputs = 0.
  - rdata outputs, mem_addr and mem_wdata = 0.
  - grant = 1, so requester 0 wins the first tie.
  - Timeout counter = 0.
- IDLE:
  - Eligible requester = req=1 and its own ack not high this cycle. The ack mask lets a requester drop req in the cycle after ack without being re-granted.
  - One eligible requester: it wins.
  - Both eligible: the winner is the requester other than grant (round-robin).
  - On the clock edge, latch the winner's addr, we and wdata, update grant, set busy, and enter ACCESS.
  - No eligible requester: stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values.
  - mem_read = !we_latched; mem_write = we_latched. The strobes are registered and constant for the whole access.
  - Requester inputs are ignored; a req dropped mid-access does not abort the transaction.
- Completion (edge where mem_ready = 1 is sampled in ACCESS):
  - Next cycle: the owner's ack = 1 and err = 0, and for a read its rdata = sampled mem_rdata.
  - Strobes and busy drop, counter clears, state returns to IDLE.
- Timeout:
  - The counter increments on each ACCESS cycle without mem_ready.
  - When the counter equals TIMEOUT-1 and mem_ready = 0, complete as above but with err = 1 and rdata = ERR_DATA for reads. A write returns rdata unchanged.
  - mem_ready and timeout coinciding: mem_ready wins, err = 0.
- Latency: req high at cycle 0 and mem_ready high at the first ACCESS cycle gives ack in cycle 2.
- Throughput: one access per 3 cycles per requester; back-to-back alternating requesters gives one access every 2 cycles.
- rdata holds its last value when ack = 0. The non-owner's ack is always 0.
- mem_ready outside ACCESS is ignored.
- Reset asserted in any state, including mid-ACCESS:
  - Strobes and ack drop immediately (asynchronous).
  - The in-flight transaction is lost with no ack.
  - Resumes in IDLE with grant = 1.

Test Plan:
1. m0 read of 0x8000, memory returns 0x12345678 with mem_ready in the first ACCESS cycle -> mem_read=1 for 1 cycle with mem_addr=0x8000; m0_ack=1, m0_err=0 and m0_rdata=0x12345678 in cycle 2; m1_ack stays 0.
2. m1 write of 0xA5A5A5A5 to 0x8004, mem_ready delayed 3 cycles -> mem_write held 4 cycles with stable address and data; m1_ack in cycle 5; busy low the next cycle.
3. m0 and m1 both request continuously from reset, each dropping req for one cycle after its ack -> grant order 0,1,0,1; each requester gets 2 accesses within 8 cycles with mem_ready immediate.
4. TIMEOUT=4, m0 read, mem_ready never asserted -> exactly 4 ACCESS cycles, then m0_ack=1, m0_err=1, m0_rdata=0xDEADBEEF; the next m1 request is granted normally.
5. rst pulsed in the second ACCESS cycle of an m1 read -> mem_read falls in the same cycle and no ack is issued; after release, simultaneous requests grant m0 first.
6. mem_ready=1 exactly on the timeout cycle (TIMEOUT=4, ready in ACCESS cycle 4) -> ack with err=0 and rdata = mem_rdata.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared memory bus, one outstanding
// access at a time, with a watchdog that error-completes accesses whose ready never comes.
module mem_bus_arbiter #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 TIMEOUT  = 256,
    parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    output logic              grant,
    output logic              busy
);

    localparam int              CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_reg, state_next;
    logic                grant_reg, grant_next;
    logic                busy_reg, busy_next;
    logic                rd_reg, rd_next;
    logic                wr_reg, wr_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [1:0]          ack_reg, ack_next;
    logic [1:0]          err_reg, err_next;
    logic [DATA_W-1:0]   rdata_reg [2];
    logic [DATA_W-1:0]   rdata_next [2];

    logic [1:0]          req_vec;
    logic [1:0]          elig;
    logic                win;

    assign req_vec = {m1_req, m0_req};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            rd_reg       <= 1'b0;
            wr_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            ack_reg      <= '0;
            err_reg      <= '0;
            rdata_reg[0] <= '0;
            rdata_reg[1] <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            busy_reg     <= busy_next;
            rd_reg       <= rd_next;
            wr_reg       <= wr_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            cnt_reg      <= cnt_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            rdata_reg[0] <= rdata_next[0];
            rdata_reg[1] <= rdata_next[1];
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        busy_next     = busy_reg;
        rd_next       = rd_reg;
        wr_next       = wr_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        cnt_next      = cnt_reg;
        ack_next      = '0;
        err_next      = '0;
        rdata_next[0] = rdata_reg[0];
        rdata_next[1] = rdata_reg[1];
        // A requester whose ack is showing this cycle may still hold req; mask it.
        elig          = req_vec & ~ack_reg;
        win           = grant_reg;

        case (state_reg)
            IDLE: begin
                if (elig != 2'b00) begin
                    win        = (elig == 2'b11) ? ~grant_reg : elig[1];
                    grant_next = win;
                    addr_next  = win ? m1_addr  : m0_addr;
                    wdata_next = win ? m1_wdata : m0_wdata;
                    wr_next    = win ? m1_we    : m0_we;
                    rd_next    = win ? ~m1_we   : ~m0_we;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Ready takes priority over the watchdog when both land together.
                if (mem_ready || cnt_reg == CNT_LAST) begin
                    ack_next[grant_reg] = 1'b1;
                    err_next[grant_reg] = ~mem_ready;
                    if (!wr_reg)
                        rdata_next[grant_reg] = mem_ready ? mem_rdata : ERR_DATA;
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign m0_ack    = ack_reg[0];
    assign m1_ack    = ack_reg[1];
    assign m0_err    = err_reg[0];
    assign m1_err    = err_reg[1];
    assign m0_rdata  = rdata_reg[0];
    assign m1_rdata  = rdata_reg[1];
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_read  = rd_reg;
    assign mem_write = wr_reg;
    assign grant     = grant_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand sequences
// for arbitration/reset corners, and random traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int          TO   = 4;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ready;
    logic        grant, busy;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
        .grant(grant), .busy(busy)
    );

    int          checks = 0;
    int          failures = 0;
    int          fixed_delay = 0;   // <0: slave derives its delay from the address
    int          acc_cyc = 0;
    logic        model_grant;
    logic [31:0] model_rdata [2];

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        int          exp_lat;
        int          exp_acc;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a + 32'h1233D678;
    endfunction

    function automatic int delay_of(input logic [31:0] a);
        return (fixed_delay >= 0) ? fixed_delay : int'(a[4:2]);
    endfunction

    // Cycles from req to ack for an access whose ready arrives d cycles late.
    function automatic int lat_of(input int d);
        return ((d < TO - 1) ? d : TO - 1) + 2;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v);
        if (i == 0) m0_req = v; else m1_req = v;
    endtask

    task automatic drive(input int i, input logic we, input logic [31:0] a, input logic [31:0] w);
        if (i == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = w; end
        else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = w; end
    endtask

    // Memory slave: ready after a per-access delay, random noise on ready outside accesses.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (busy) begin
                mem_ready = (acc_cyc == delay_of(mem_addr));
                mem_rdata = mem_ready ? data_of(mem_addr) : $urandom;
                acc_cyc++;
            end else begin
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
                acc_cyc   = 0;
            end
        end
    end

    task automatic do_reset();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ctrl", {m0_ack, m0_err, m1_ack, m1_err, mem_read, mem_write, busy, grant}, 64'h01);
        check("rst_data", {m0_rdata, m1_rdata}, 64'h0);
        check("rst_bus", {mem_addr, mem_wdata}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_grant    = 1'b1;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
    endtask

    task automatic run_single(input vec_t v, input int idx);
        int cyc = 0, lat = -1, acc = 0;
        logic seen = 0, bus_ok = 1, other_ack = 0, g_err = 0, g_grant = 0;
        logic [31:0] g_rd = '0;
        fixed_delay = v.delay;
        drive(int'(v.who), v.we, v.addr, v.wdata);
        while (!seen && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) begin
                acc++;
                if (mem_read !== !v.we || mem_write !== v.we || mem_addr !== v.addr ||
                    (v.we && mem_wdata !== v.wdata)) bus_ok = 0;
            end
            if (v.who ? m0_ack : m1_ack) other_ack = 1;
            if (v.who ? m1_ack : m0_ack) begin
                seen = 1; lat = cyc; g_grant = grant;
                g_err = v.who ? m1_err : m0_err;
                g_rd  = v.who ? m1_rdata : m0_rdata;
            end
        end
        check($sformatf("v%0d_ack_seen", idx), seen, 1);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_access_cycles", idx), acc, v.exp_acc);
        check($sformatf("v%0d_bus", idx), bus_ok, 1);
        check($sformatf("v%0d_other_ack", idx), other_ack, 0);
        check($sformatf("v%0d_err", idx), g_err, v.exp_err);
        check($sformatf("v%0d_rdata", idx), g_rd, v.exp_rdata);
        check($sformatf("v%0d_grant_busy", idx), {g_grant, busy}, {v.who, 1'b0});
        // req is still high during the ack cycle; it must not be re-granted.
        @(posedge clk); #1;
        set_req(int'(v.who), 1'b0);
        check($sformatf("v%0d_after", idx), {m0_ack, m1_ack, busy}, 3'b000);
        $display("vector %0d: m%0d we=%0d addr=%08h lat=%0d err=%0d rdata=%08h",
                 idx, v.who, v.we, v.addr, lat, g_err, g_rd);
    endtask

    task automatic run_random(input int n);
        logic [1:0]  reqs;
        logic [31:0] a [2];
        logic [31:0] w [2];
        logic        we [2];
        int          d [2], exp_cyc [2], got_cyc [2];
        logic        got_err [2], acked [2], prev [2], exp_err [2];
        logic [31:0] got_rd [2];
        int          first, second, cyc;
        logic        dup;
        int          order [$];
        fixed_delay = -1;
        reqs = 2'($urandom_range(1, 3));
        for (int i = 0; i < 2; i++) begin
            a[i] = {16'h0, 16'($urandom) & 16'hFFFC};
            w[i] = $urandom;
            we[i] = 1'($urandom);
            d[i] = int'(a[i][4:2]);
            exp_err[i] = (d[i] > TO - 1);
            got_cyc[i] = -1; got_err[i] = 0; got_rd[i] = '0; acked[i] = 0; prev[i] = 0;
        end
        if (reqs == 2'b11) begin
            first  = model_grant ? 0 : 1;
            second = model_grant ? 1 : 0;
        end else begin
            first  = reqs[1] ? 1 : 0;
            second = -1;
        end
        exp_cyc[first] = lat_of(d[first]);
        if (second >= 0) exp_cyc[second] = exp_cyc[first] + lat_of(d[second]);
        for (int i = 0; i < 2; i++) if (reqs[i]) drive(i, we[i], a[i], w[i]);
        cyc = 0; dup = 0;
        while (!((acked[0] || !reqs[0]) && (acked[1] || !reqs[1])) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                logic ak;
                ak = (i == 0) ? m0_ack : m1_ack;
                if (prev[i]) set_req(i, 1'b0);
                if (ak) begin
                    if (acked[i] || !reqs[i]) dup = 1;
                    acked[i] = 1; got_cyc[i] = cyc; order.push_back(i);
                    got_err[i] = (i == 0) ? m0_err : m1_err;
                    got_rd[i]  = (i == 0) ? m0_rdata : m1_rdata;
                end
                prev[i] = ak;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (reqs[i]) begin
                if (!we[i]) model_rdata[i] = exp_err[i] ? ERRD : data_of(a[i]);
                check($sformatf("r%0d_m%0d_cycle", n, i), got_cyc[i], exp_cyc[i]);
                check($sformatf("r%0d_m%0d_err", n, i), got_err[i], exp_err[i]);
                check($sformatf("r%0d_m%0d_rdata", n, i), got_rd[i], model_rdata[i]);
            end
        end
        check($sformatf("r%0d_first", n), (order.size() > 0) ? order[0] : -1, first);
        check($sformatf("r%0d_dup", n), dup, 0);
        model_grant = (second >= 0) ? 1'(second) : 1'(first);
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
        check($sformatf("r%0d_idle", n), {m0_ack, m1_ack, busy, grant}, {3'b000, model_grant});
        check($sformatf("r%0d_hold", n), {m0_rdata, m1_rdata}, {model_rdata[0], model_rdata[1]});
        $display("random %0d: reqs=%b first=m%0d d0=%0d d1=%0d we0=%0d we1=%0d",
                 n, reqs, first, d[0], d[1], we[0], we[1]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h8000, 32'h0,        0, 2, 1, 1'b0, 32'h12345678};
        vecs[1] = '{1'b1, 1'b1, 32'h8004, 32'hA5A5A5A5, 3, 5, 4, 1'b0, 32'h00000000};
        vecs[2] = '{1'b0, 1'b0, 32'h0010, 32'h0,        9, 5, 4, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0100, 32'h0,        1, 3, 2, 1'b0, 32'h1233D778};
        vecs[4] = '{1'b0, 1'b1, 32'h0020, 32'h11,       2, 4, 3, 1'b0, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b1, 32'h0040, 32'h22,       9, 5, 4, 1'b1, 32'h1233D778};
        vecs[6] = '{1'b0, 1'b0, 32'h0200, 32'h0,        3, 5, 4, 1'b0, 32'h1233D878};

        do_reset();
        for (int i = 0; i < 7; i++) run_single(vecs[i], i);

        // Both requesting from reset, each dropping req for one cycle after its ack.
        begin
            int   ack_cyc [$];
            int   ack_who [$];
            logic prev0 = 0, prev1 = 0, a0, a1;
            do_reset();
            fixed_delay = 0;
            drive(0, 1'b0, 32'h1000, 32'h0);
            drive(1, 1'b0, 32'h2000, 32'h0);
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); #1;
                a0 = m0_ack; a1 = m1_ack;
                m0_req = !prev0;
                m1_req = !prev1;
                if (a0) begin ack_cyc.push_back(c); ack_who.push_back(0); end
                if (a1) begin ack_cyc.push_back(c); ack_who.push_back(1); end
                prev0 = a0; prev1 = a1;
            end
            check("rr_ack_count", ack_cyc.size(), 4);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rr_owner%0d", k), (k < ack_who.size()) ? ack_who[k] : -1, k % 2);
                check($sformatf("rr_cycle%0d", k), (k < ack_cyc.size()) ? ack_cyc[k] : -1, 2 + 2 * k);
            end
            $display("round robin: %0d acks in 8 cycles", ack_cyc.size());
        end

        // Reset during the second access cycle of an m1 read.
        begin
            logic stray = 0;
            do_reset();
            fixed_delay = 100;
            drive(1, 1'b0, 32'h0300, 32'h0);
            @(posedge clk); #1;
            check("rst_mid_busy", busy, 1);
            @(posedge clk); #1;
            check("rst_mid_read_before", mem_read, 1);
            #2 rst = 1'b1;
            #1;
            check("rst_mid_async", {mem_read, mem_write, busy, m1_ack, grant}, 5'b00001);
            m1_req = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (m0_ack || m1_ack || busy) stray = 1;
            end
            check("rst_mid_no_ack", stray, 0);
            fixed_delay = 0;
            drive(0, 1'b0, 32'h0400, 32'h0);
            drive(1, 1'b0, 32'h0404, 32'h0);
            @(posedge clk); #1;
            check("rst_tie_grant0", {grant, busy}, 2'b01);
            @(posedge clk); #1;
            check("rst_tie_ack0", {m0_ack, m1_ack, m0_rdata}, {2'b10, data_of(32'h0400)});
            m0_req = 1'b0;
            @(posedge clk); #1;
            check("rst_tie_grant1", {grant, busy}, 2'b11);
            @(posedge clk); #1;
            check("rst_tie_ack1", {m0_ack, m1_ack, m1_rdata}, {2'b01, data_of(32'h0404)});
            m1_req = 1'b0;
            @(posedge clk); #1;
            $display("reset mid-access sequence done");
        end

        do_reset();
        for (int n = 0; n < 40; n++) run_random(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
